fp_round_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational mantissa rounder.
- Applies the IEEE-754 rounding mode to a sign/exponent/mantissa triple with guard, round and sticky bits.
- Resolves mantissa carry-out into the exponent, detects overflow to infinity and raises the inexact flag.
- Sits between the add/mul normaliser and the result writeback, with valid/ready handshakes on both sides.

---
 rtl/fp_pkg.sv | 38 +++
 rtl/fp_round_decide.sv | 35 +++
 rtl/fp_round_pipe.sv | 146 ++++++++++++++
 tb/tb_fp_round_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point rounding path.
// - rm_e        : rounding-mode encoding carried on in_rm.
// - rm_legal    : true when a 3-bit mode value is one of the defined modes.
// - round_up_fn : increment decision for a truncated mantissa given its LSB,
//                 guard, round and sticky bits.
package fp_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rm_e;

  function automatic logic rm_legal(input logic [2:0] rm);
    return rm <= 3'b100;
  endfunction

  function automatic logic round_up_fn(input logic [2:0] rm,
                                       input logic       sign,
                                       input logic       lsb,
                                       input logic       g,
                                       input logic       r,
                                       input logic       s);
    logic up;
    up = 1'b0;
    case (rm)
      RNE:     up = g & (r | s | lsb);
      RDN:     up = sign & (g | r | s);
      RUP:     up = ~sign & (g | r | s);
      RMM:     up = g;
      default: up = 1'b0;  // RTZ and illegal modes truncate
    endcase
    return up;
  endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Combinational rounding decision for one operation.
// Inputs : rounding mode, sign, special flag (inf/NaN exponent), truncated
//          mantissa and the guard/round/sticky bits below it.
// Outputs: mantissa plus the round increment (one extra bit for carry-out),
//          inexact and illegal-mode flags.
module fp_round_decide #(
  parameter int unsigned MANT_W = 23
) (
  input  logic [2:0]        rm_i,
  input  logic              sign_i,
  input  logic              special_i,
  input  logic [MANT_W-1:0] mant_i,
  input  logic              guard_i,
  input  logic              round_i,
  input  logic              sticky_i,
  output logic [MANT_W:0]   mant_p1_o,
  output logic              inexact_o,
  output logic              bad_rm_o
);
  import fp_pkg::*;

  logic legal;
  logic round_up;

  assign legal = rm_legal(rm_i);

  // Illegal modes fall back to truncation; inf/NaN is never rounded.
  assign round_up = ~special_i & legal &
                    round_up_fn(rm_i, sign_i, mant_i[0], guard_i, round_i, sticky_i);

  assign mant_p1_o = {1'b0, mant_i} + {{MANT_W{1'b0}}, round_up};
  assign inexact_o = ~special_i & (guard_i | round_i | sticky_i);
  assign bad_rm_o  = ~special_i & ~legal;

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage pipelined IEEE-754 mantissa rounder with valid/ready on both sides.
// S1 takes the rounding decision and increments the mantissa; S2 folds any
// mantissa carry into the exponent and flags overflow to infinity.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   in_valid / in_ready        : input handshake
//   in_sign/exp/mant           : normalised operand, truncated mantissa
//   in_guard/round/sticky      : bits below the mantissa LSB
//   in_rm, in_tag              : rounding mode, opaque sideband tag
//   out_valid / out_ready      : output handshake
//   out_sign/exp/mant/tag      : rounded result
//   out_inexact/overflow/bad_rm: status flags
module fp_round_pipe #(
  parameter int unsigned MANT_W = 23,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_guard,
  input  logic              in_round,
  input  logic              in_sticky,
  input  logic [2:0]        in_rm,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_inexact,
  output logic              out_overflow,
  output logic              out_bad_rm,
  output logic [TAG_W-1:0]  out_tag
);
  import fp_pkg::*;

  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  logic s1_adv, s2_adv;
  logic s1_valid_q, s2_valid_q;

  assign s2_adv    = ~s2_valid_q | out_ready;
  assign s1_adv    = ~s1_valid_q | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;

  // ---------------- S1: rounding decision ----------------
  logic              in_special;
  logic [MANT_W:0]   dec_mant_p1;
  logic              dec_inexact, dec_bad_rm;

  assign in_special = (in_exp == EXP_ONES);

  fp_round_decide #(
    .MANT_W(MANT_W)
  ) u_decide (
    .rm_i      (in_rm),
    .sign_i    (in_sign),
    .special_i (in_special),
    .mant_i    (in_mant),
    .guard_i   (in_guard),
    .round_i   (in_round),
    .sticky_i  (in_sticky),
    .mant_p1_o (dec_mant_p1),
    .inexact_o (dec_inexact),
    .bad_rm_o  (dec_bad_rm)
  );

  logic              s1_sign_q;
  logic [EXP_W-1:0]  s1_exp_q;
  logic [MANT_W:0]   s1_mant_p1_q;
  logic              s1_inexact_q, s1_bad_rm_q;
  logic [TAG_W-1:0]  s1_tag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_mant_p1_q <= '0;
      s1_inexact_q <= 1'b0;
      s1_bad_rm_q  <= 1'b0;
      s1_tag_q     <= '0;
    end else begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (s1_adv && in_valid) begin
        s1_sign_q    <= in_sign;
        s1_exp_q     <= in_exp;
        s1_mant_p1_q <= dec_mant_p1;
        s1_inexact_q <= dec_inexact;
        s1_bad_rm_q  <= dec_bad_rm;
        s1_tag_q     <= in_tag;
      end
    end
  end

  // ---------------- S2: carry resolution ----------------
  logic [EXP_W-1:0]  exp_inc;
  logic [EXP_W-1:0]  s2_exp_d;
  logic [MANT_W-1:0] s2_mant_d;
  logic              s2_ovf_d;

  assign exp_inc = s1_exp_q + 1'b1;

  // Special operands never carry, so they pass through this path untouched.
  always_comb begin
    s2_exp_d  = s1_exp_q;
    s2_mant_d = s1_mant_p1_q[MANT_W-1:0];
    s2_ovf_d  = 1'b0;
    if (s1_mant_p1_q[MANT_W]) begin
      s2_exp_d  = exp_inc;
      s2_mant_d = '0;
      s2_ovf_d  = (exp_inc == EXP_ONES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q   <= 1'b0;
      out_sign     <= 1'b0;
      out_exp      <= '0;
      out_mant     <= '0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
      out_bad_rm   <= 1'b0;
      out_tag      <= '0;
    end else begin
      if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s2_adv && s1_valid_q) begin
        out_sign     <= s1_sign_q;
        out_exp      <= s2_exp_d;
        out_mant     <= s2_mant_d;
        out_inexact  <= s1_inexact_q | s2_ovf_d;
        out_overflow <= s2_ovf_d;
        out_bad_rm   <= s1_bad_rm_q;
        out_tag      <= s1_tag_q;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Scoreboard bench for fp_round_pipe: accepted inputs are modelled and queued,
// a monitor compares every presented output against the queue head.
module tb_fp_round_pipe;

  logic        clk, reset;
  logic        in_valid, in_ready, in_sign, in_guard, in_round, in_sticky;
  logic [7:0]  in_exp;
  logic [22:0] in_mant;
  logic [2:0]  in_rm;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready, out_sign, out_inexact, out_overflow, out_bad_rm;
  logic [7:0]  out_exp;
  logic [22:0] out_mant;
  logic [3:0]  out_tag;

  fp_round_pipe #(.MANT_W(23), .EXP_W(8), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_exp(in_exp),
    .in_mant(in_mant), .in_guard(in_guard), .in_round(in_round), .in_sticky(in_sticky),
    .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
    .out_mant(out_mant), .out_inexact(out_inexact), .out_overflow(out_overflow),
    .out_bad_rm(out_bad_rm), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic sign; logic [7:0] exp; logic [22:0] mant;
    logic g; logic r; logic s; logic [2:0] rm; logic [3:0] tag;
  } op_t;

  typedef struct {
    logic sign; logic [7:0] exp; logic [22:0] mant;
    logic inexact; logic overflow; logic bad_rm; logic [3:0] tag;
    int acc_cyc; bit lat_chk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  bit   lat_mode = 0;
  bit   rnd_bp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: value of the dropped fraction vs half an ULP, then integer add.
  function automatic exp_t model(op_t o);
    exp_t        e;
    int unsigned m;
    int unsigned mode;
    bit          up, above, tie, nz;
    e.sign = o.sign; e.tag = o.tag; e.exp = o.exp; e.mant = o.mant;
    e.inexact = 0; e.overflow = 0; e.bad_rm = 0; e.acc_cyc = 0; e.lat_chk = 0;
    if (o.exp == 8'hFF) return e;
    e.bad_rm = (o.rm > 3'd4);
    mode  = e.bad_rm ? 1 : int'(o.rm);
    nz    = o.g || o.r || o.s;
    above = o.g && (o.r || o.s);
    tie   = o.g && !o.r && !o.s;
    e.inexact = nz;
    case (mode)
      0:       up = above || (tie && (o.mant % 2 == 1));
      2:       up = o.sign && nz;
      3:       up = !o.sign && nz;
      4:       up = o.g;
      default: up = 0;
    endcase
    m = int'(o.mant) + (up ? 1 : 0);
    if (m == (1 << 23)) begin
      m = 0;
      e.exp = o.exp + 8'd1;
      e.overflow = (e.exp == 8'hFF);
    end
    e.mant = m[22:0];
    return e;
  endfunction

  // Accept capture: model each accepted op and queue its expected result.
  always @(negedge clk) begin
    op_t  o;
    exp_t e;
    if (!reset && in_valid && in_ready) begin
      o.sign = in_sign; o.exp = in_exp; o.mant = in_mant;
      o.g = in_guard; o.r = in_round; o.s = in_sticky; o.rm = in_rm; o.tag = in_tag;
      e = model(o);
      e.acc_cyc = cyc;
      e.lat_chk = lat_mode;
      sb.push_back(e);
      acc_cnt = acc_cnt + 1;
    end
  end

  // Monitor: every presented output must match the queue head (also while stalled).
  always @(negedge clk) begin
    logic [38:0] act, req;
    if (!reset && out_valid) begin
      act = {out_sign, out_exp, out_mant, out_inexact, out_overflow, out_bad_rm, out_tag};
      checks = checks + 1;
      if (sb.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_out got=%h required=no output", act);
      end else begin
        req = {sb[0].sign, sb[0].exp, sb[0].mant, sb[0].inexact, sb[0].overflow,
               sb[0].bad_rm, sb[0].tag};
        if (act !== req) begin
          failures = failures + 1;
          $display("FAIL result got=%h required=%h", act, req);
        end
        if (out_ready) begin
          if (sb[0].lat_chk) begin
            checks = checks + 1;
            if (cyc - sb[0].acc_cyc != 2) begin
              failures = failures + 1;
              $display("FAIL latency got=%0d required=2", cyc - sb[0].acc_cyc);
            end
          end
          void'(sb.pop_front());
        end
      end
    end
  end

  // Random backpressure when enabled.
  always @(posedge clk) begin
    if (rnd_bp) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks = checks + 1;
    if (got !== req) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic send(input op_t o);
    bit done;
    done = 0;
    in_sign = o.sign; in_exp = o.exp; in_mant = o.mant; in_guard = o.g;
    in_round = o.r; in_sticky = o.s; in_rm = o.rm; in_tag = o.tag;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL send_timeout got=not accepted required=accepted");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  function automatic op_t mk(logic sign, logic [7:0] exp, logic [22:0] mant,
                             logic g, logic r, logic s, logic [2:0] rm, logic [3:0] tag);
    op_t o;
    o.sign = sign; o.exp = exp; o.mant = mant; o.g = g; o.r = r; o.s = s;
    o.rm = rm; o.tag = tag;
    return o;
  endfunction

  initial begin
    op_t o;
    op_t dir[$];
    in_valid = 0; in_sign = 0; in_exp = 0; in_mant = 0; in_guard = 0; in_round = 0;
    in_sticky = 0; in_rm = 0; in_tag = 0; out_ready = 1; reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_payload", 64'({out_sign, out_exp, out_mant, out_inexact, out_overflow,
                              out_bad_rm, out_tag}), 64'd0);

    // Directed cases, one at a time with latency check
    dir.push_back(mk(0, 8'h7F, 23'h000001, 1, 0, 0, 3'd0, 4'h1)); // RNE tie -> even up
    dir.push_back(mk(0, 8'h7F, 23'h000000, 1, 0, 0, 3'd0, 4'h2)); // RNE tie stays even
    dir.push_back(mk(0, 8'h80, 23'h7FFFFF, 1, 0, 0, 3'd0, 4'h3)); // mantissa carry
    dir.push_back(mk(0, 8'hFE, 23'h7FFFFF, 1, 0, 0, 3'd3, 4'h4)); // RUP overflow
    dir.push_back(mk(0, 8'hFE, 23'h7FFFFF, 1, 0, 0, 3'd2, 4'h5)); // RDN no round
    dir.push_back(mk(0, 8'h00, 23'h7FFFFF, 0, 0, 1, 3'd3, 4'h6)); // subnormal promote
    dir.push_back(mk(0, 8'hFF, 23'h400000, 1, 0, 0, 3'd0, 4'h7)); // NaN passthrough
    dir.push_back(mk(1, 8'h40, 23'h123457, 1, 1, 0, 3'd7, 4'h8)); // illegal rm
    dir.push_back(mk(1, 8'h40, 23'h123456, 1, 0, 0, 3'd4, 4'h9)); // RMM
    lat_mode = 1;
    foreach (dir[i]) begin
      send(dir[i]);
      drain();
    end
    lat_mode = 0;

    // Backpressure: 4 tagged ops, out_ready low for 3 cycles
    out_ready = 0;
    acc_cnt = 0;
    fork
      begin
        for (int t = 1; t <= 4; t++)
          send(mk(0, 8'h10, 23'(t * 1000), 1, 1, 0, 3'd0, 4'(t)));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        check("bp_accepts", 64'(acc_cnt), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1;
      end
    join
    drain();

    // Reset with both stages full
    out_ready = 0;
    send(mk(0, 8'h20, 23'h000100, 1, 0, 1, 3'd0, 4'hA));
    send(mk(0, 8'h21, 23'h000200, 0, 1, 0, 3'd3, 4'hB));
    reset = 1;
    sb.delete();
    @(posedge clk);
    #1 reset = 0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_payload", 64'({out_sign, out_exp, out_mant, out_inexact, out_overflow,
                                out_bad_rm, out_tag}), 64'd0);
    out_ready = 1;
    repeat (5) @(posedge clk);
    #1;

    // Random traffic with random backpressure
    rnd_bp = 1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0:       o.exp = 8'h00;
        1:       o.exp = 8'hFE;
        2:       o.exp = 8'hFF;
        default: o.exp = 8'($urandom);
      endcase
      o.mant = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
      o.sign = 1'($urandom); o.g = 1'($urandom); o.r = 1'($urandom); o.s = 1'($urandom);
      o.rm = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      o.tag = 4'($urandom);
      send(o);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_bp = 0;
    @(posedge clk);
    #1 out_ready = 1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
